// File: rtl/polygon_table_writer.sv
`default_nettype none
//------------------------------------------------------------------------------
// polygon_table_writer: builds a back-bank polygon table from a vertex stream
// and publishes it as the front bank on a frame swap.  Revision: 1.0
//------------------------------------------------------------------------------
module polygon_table_writer #(
  parameter int MAX_NUM_VERTICES       = 8,
  parameter int MAX_POLYGONS_ON_SCREEN = 4
) (
  input  logic                                                   clk_in,
  input  logic                                                   rst_in,
  input  logic                                                   vert_valid_in,
  output logic                                                   vert_ready_out,
  input  logic [31:0]                                            vert_x_in,
  input  logic [31:0]                                            vert_y_in,
  input  logic                                                   vert_last_in,
  input  logic                                                   scene_end_in,
  input  logic                                                   swap_in,
  output logic [MAX_POLYGONS_ON_SCREEN*MAX_NUM_VERTICES*32-1:0]  xs_out,
  output logic [MAX_POLYGONS_ON_SCREEN*MAX_NUM_VERTICES*32-1:0]  ys_out,
  output logic [MAX_POLYGONS_ON_SCREEN*$clog2(MAX_NUM_VERTICES+1)-1:0] num_sides_out,
  output logic [$clog2(MAX_POLYGONS_ON_SCREEN+1)-1:0]            polygons_on_screen_out,
  output logic                                                   overflow_out
);

  localparam int NV     = MAX_NUM_VERTICES;
  localparam int NP     = MAX_POLYGONS_ON_SCREEN;
  localparam int SLOTS  = NP * NV;
  localparam int VI_W   = $clog2(NV + 1);
  localparam int PI_W   = $clog2(NP + 1);
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int PSEL_W = (NP > 1) ? $clog2(NP) : 1;

  localparam logic [VI_W-1:0] c_vert_max  = VI_W'(NV);
  localparam logic [PI_W-1:0] c_poly_max  = PI_W'(NP);
  localparam logic [VI_W-1:0] c_min_sides = VI_W'(3);

  typedef logic [SLOTS-1:0][31:0]    coord_bank_t;
  typedef logic [NP-1:0][VI_W-1:0]   sides_bank_t;

  typedef enum logic [0:0] {
    S_FILL      = 1'b0,
    S_COMMITTED = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    ready_en_q, ready_en_d;
  logic                    front_q, front_d;
  logic [PI_W-1:0]         poly_idx_q, poly_idx_d;
  logic [VI_W-1:0]         vert_idx_q, vert_idx_d;
  coord_bank_t [1:0]       xs_q, xs_d;
  coord_bank_t [1:0]       ys_q, ys_d;
  sides_bank_t [1:0]       sides_q, sides_d;
  logic [1:0][PI_W-1:0]    count_q, count_d;
  logic [1:0]              ovf_q, ovf_d;

  coord_bank_t             xs_out_q, xs_out_d;
  coord_bank_t             ys_out_q, ys_out_d;
  sides_bank_t             sides_out_q, sides_out_d;
  logic [PI_W-1:0]         count_out_q, count_out_d;
  logic                    ovf_out_q, ovf_out_d;

  logic                    back;
  logic                    beat;
  logic                    vert_fits;
  logic                    poly_fits;
  logic [PSEL_W-1:0]       poly_sel;
  logic [SLOT_W-1:0]       slot;
  logic [VI_W-1:0]         n_sides;

  assign back           = ~front_q;
  assign vert_ready_out = ready_en_q && (state_q == S_FILL);
  assign beat           = vert_valid_in && vert_ready_out;
  assign vert_fits      = (vert_idx_q < c_vert_max);
  assign poly_fits      = (poly_idx_q < c_poly_max);
  assign poly_sel       = poly_idx_q[PSEL_W-1:0];
  assign slot           = SLOT_W'(poly_sel) * SLOT_W'(NV) + SLOT_W'(vert_idx_q);
  assign n_sides        = vert_fits ? (vert_idx_q + VI_W'(1)) : c_vert_max;

  always_comb begin
    state_d     = state_q;
    ready_en_d  = 1'b1;
    front_d     = front_q;
    poly_idx_d  = poly_idx_q;
    vert_idx_d  = vert_idx_q;
    xs_d        = xs_q;
    ys_d        = ys_q;
    sides_d     = sides_q;
    count_d     = count_q;
    ovf_d       = ovf_q;

    if (beat) begin
      if (vert_fits) begin
        // Vertices of a polygon beyond the table capacity have no slot to land in.
        if (poly_fits) begin
          xs_d[back][slot] = vert_x_in;
          ys_d[back][slot] = vert_y_in;
        end
        vert_idx_d = vert_idx_q + VI_W'(1);
      end else begin
        ovf_d[back] = 1'b1;
        vert_idx_d  = c_vert_max;
      end

      if (vert_last_in) begin
        vert_idx_d = '0;
        if (n_sides >= c_min_sides) begin
          if (poly_fits) begin
            sides_d[back][poly_sel] = n_sides;
            poly_idx_d              = poly_idx_q + PI_W'(1);
          end else begin
            ovf_d[back] = 1'b1;
          end
        end
      end
    end

    // A beat in the same cycle is folded in first via poly_idx_d.
    if ((state_q == S_FILL) && scene_end_in) begin
      count_d[back] = poly_idx_d;
      vert_idx_d    = '0;
      state_d       = S_COMMITTED;
    end else if ((state_q == S_COMMITTED) && swap_in) begin
      front_d          = ~front_q;
      state_d          = S_FILL;
      poly_idx_d       = '0;
      vert_idx_d       = '0;
      count_d[front_q] = '0;
      ovf_d[front_q]   = 1'b0;
      sides_d[front_q] = '0;
    end

    xs_out_d    = xs_q[front_q];
    ys_out_d    = ys_q[front_q];
    sides_out_d = sides_q[front_q];
    count_out_d = count_q[front_q];
    ovf_out_d   = ovf_q[front_q];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_FILL;
      ready_en_q  <= 1'b0;
      front_q     <= 1'b0;
      poly_idx_q  <= '0;
      vert_idx_q  <= '0;
      xs_q        <= '0;
      ys_q        <= '0;
      sides_q     <= '0;
      count_q     <= '0;
      ovf_q       <= '0;
      xs_out_q    <= '0;
      ys_out_q    <= '0;
      sides_out_q <= '0;
      count_out_q <= '0;
      ovf_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_en_q  <= ready_en_d;
      front_q     <= front_d;
      poly_idx_q  <= poly_idx_d;
      vert_idx_q  <= vert_idx_d;
      xs_q        <= xs_d;
      ys_q        <= ys_d;
      sides_q     <= sides_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      xs_out_q    <= xs_out_d;
      ys_out_q    <= ys_out_d;
      sides_out_q <= sides_out_d;
      count_out_q <= count_out_d;
      ovf_out_q   <= ovf_out_d;
    end
  end

  assign xs_out                 = xs_out_q;
  assign ys_out                 = ys_out_q;
  assign num_sides_out          = sides_out_q;
  assign polygons_on_screen_out = count_out_q;
  assign overflow_out           = ovf_out_q;

endmodule
`default_nettype wire

// File: tb/tb_polygon_table_writer.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_polygon_table_writer: scoreboard bench for the double-buffered table writer.
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_polygon_table_writer;

  localparam int V   = 8;
  localparam int P   = 4;
  localparam int TOT = P * V;
  localparam int NSW = $clog2(V + 1);
  localparam int PW  = $clog2(P + 1);

  logic                 clk_in;
  logic                 rst_in;
  logic                 vert_valid_in;
  logic                 vert_ready_out;
  logic [31:0]          vert_x_in;
  logic [31:0]          vert_y_in;
  logic                 vert_last_in;
  logic                 scene_end_in;
  logic                 swap_in;
  logic [TOT*32-1:0]    xs_out;
  logic [TOT*32-1:0]    ys_out;
  logic [P*NSW-1:0]     num_sides_out;
  logic [PW-1:0]        polygons_on_screen_out;
  logic                 overflow_out;

  polygon_table_writer #(
    .MAX_NUM_VERTICES       (V),
    .MAX_POLYGONS_ON_SCREEN (P)
  ) dut (
    .clk_in                 (clk_in),
    .rst_in                 (rst_in),
    .vert_valid_in          (vert_valid_in),
    .vert_ready_out         (vert_ready_out),
    .vert_x_in              (vert_x_in),
    .vert_y_in              (vert_y_in),
    .vert_last_in           (vert_last_in),
    .scene_end_in           (scene_end_in),
    .swap_in                (swap_in),
    .xs_out                 (xs_out),
    .ys_out                 (ys_out),
    .num_sides_out          (num_sides_out),
    .polygons_on_screen_out (polygons_on_screen_out),
    .overflow_out           (overflow_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [PW-1:0]     count;
    logic [TOT*32-1:0] xs;
    logic [TOT*32-1:0] ys;
    logic [TOT-1:0]    vmask;
    logic [P*NSW-1:0]  sides;
    logic              ovf;
  } scene_t;

  int     errors = 0;
  int     checks = 0;
  scene_t sb[$];
  scene_t cur;
  scene_t last_exp;
  scene_t e;
  bit     m_fill;
  int     m_poly;
  int     m_vidx;

  // Reference model of the back bank being built.
  function automatic void model_clear();
    cur.count = '0;
    cur.xs    = '0;
    cur.ys    = '0;
    cur.vmask = '0;
    cur.sides = '0;
    cur.ovf   = 1'b0;
    m_poly    = 0;
    m_vidx    = 0;
    m_fill    = 1'b1;
  endfunction

  function automatic void model_beat(input logic [31:0] x, input logic [31:0] y, input bit last);
    int n;
    if (m_vidx < V) begin
      if (m_poly < P) begin
        cur.xs[(m_poly*V + m_vidx)*32 +: 32] = x;
        cur.ys[(m_poly*V + m_vidx)*32 +: 32] = y;
      end
    end else begin
      cur.ovf = 1'b1;
    end
    n      = (m_vidx + 1 < V) ? m_vidx + 1 : V;
    m_vidx = n;
    if (last) begin
      if (n >= 3) begin
        if (m_poly < P) begin
          cur.sides[m_poly*NSW +: NSW] = NSW'(n);
          m_poly++;
        end else begin
          cur.ovf = 1'b1;
        end
      end
      m_vidx = 0;
    end
  endfunction

  function automatic void model_commit();
    int ns;
    cur.count = PW'(m_poly);
    cur.vmask = '0;
    for (int p = 0; p < m_poly; p++) begin
      ns = int'(cur.sides[p*NSW +: NSW]);
      for (int v = 0; v < ns; v++) cur.vmask[p*V + v] = 1'b1;
    end
    sb.push_back(cur);
    m_fill = 1'b0;
    m_vidx = 0;
  endfunction

  // All stimulus tasks start and end on a falling edge.
  task automatic send_beat(input logic [31:0] x, input logic [31:0] y, input bit last, input bit se);
    bit acc;
    bit fill;
    vert_valid_in = 1'b1;
    vert_x_in     = x;
    vert_y_in     = y;
    vert_last_in  = last;
    scene_end_in  = se;
    acc           = vert_ready_out;
    fill          = m_fill;
    @(posedge clk_in);
    if (acc) model_beat(x, y, last);
    if (se && fill) model_commit();
    @(negedge clk_in);
    vert_valid_in = 1'b0;
    vert_last_in  = 1'b0;
    scene_end_in  = 1'b0;
  endtask

  task automatic send_poly(input int n, input int base);
    for (int i = 0; i < n; i++)
      send_beat(32'(base + 17*i), 32'(base*3 - 5*i), (i == n-1), 1'b0);
  endtask

  task automatic ctl(input bit se, input bit sw);
    bit fill;
    scene_end_in = se;
    swap_in      = sw;
    fill         = m_fill;
    @(posedge clk_in);
    if (fill && se) model_commit();
    else if (!fill && sw) model_clear();
    @(negedge clk_in);
    scene_end_in = 1'b0;
    swap_in      = 1'b0;
  endtask

  task automatic do_swap();
    ctl(1'b0, 1'b1);
    @(negedge clk_in);
  endtask

  task automatic pop_expected(input string tag);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_pop: scoreboard empty, expected one committed scene", tag);
      e = cur;
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic test_reset();
    rst_in        = 1'b0;
    vert_valid_in = 1'b0;
    vert_x_in     = '0;
    vert_y_in     = '0;
    vert_last_in  = 1'b0;
    scene_end_in  = 1'b0;
    swap_in       = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++; if (vert_ready_out !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", vert_ready_out); end
    checks++; if (polygons_on_screen_out !== '0) begin errors++; $display("FAIL rst_count: got %0d expected 0", polygons_on_screen_out); end
    checks++; if (num_sides_out !== '0) begin errors++; $display("FAIL rst_sides: got %h expected 0", num_sides_out); end
    checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", overflow_out); end
    checks++; if ((xs_out !== '0) || (ys_out !== '0)) begin errors++; $display("FAIL rst_coords: got nonzero expected 0"); end
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    checks++; if (vert_ready_out !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", vert_ready_out); end
    checks++; if (polygons_on_screen_out !== '0) begin errors++; $display("FAIL rst_release_count: got %0d expected 0", polygons_on_screen_out); end
    @(negedge clk_in);
    model_clear();
  endtask

  task automatic test_scene1();
    send_beat(32'd100, 32'd100, 1'b0, 1'b0);
    send_beat(32'd200, 32'd100, 1'b0, 1'b0);
    send_beat(32'd200, 32'd200, 1'b0, 1'b0);
    send_beat(32'd100, 32'd200, 1'b1, 1'b0);
    send_beat(32'd300, 32'd300, 1'b0, 1'b0);
    send_beat(32'd400, 32'd100, 1'b0, 1'b0);
    send_beat(32'd500, 32'd300, 1'b1, 1'b0);
    ctl(1'b1, 1'b0);
    do_swap();
    pop_expected("s1");
    checks++; if (polygons_on_screen_out !== 3'd2) begin errors++; $display("FAIL s1_count: got %0d expected 2", polygons_on_screen_out); end
    checks++; if (num_sides_out !== 16'h0034) begin errors++; $display("FAIL s1_sides: got %h expected 0034", num_sides_out); end
    checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL s1_ovf: got %b expected 0", overflow_out); end
    checks++; if (xs_out[1*32 +: 32] !== 32'd200) begin errors++; $display("FAIL s1_x01: got %0d expected 200", xs_out[1*32 +: 32]); end
    for (int s = 0; s < TOT; s++) begin
      if (e.vmask[s]) begin
        checks++;
        if ((xs_out[s*32 +: 32] !== e.xs[s*32 +: 32]) || (ys_out[s*32 +: 32] !== e.ys[s*32 +: 32])) begin
          errors++;
          $display("FAIL s1_vertex[%0d]: got (%0d,%0d) expected (%0d,%0d)", s,
                   $signed(xs_out[s*32 +: 32]), $signed(ys_out[s*32 +: 32]),
                   $signed(e.xs[s*32 +: 32]), $signed(e.ys[s*32 +: 32]));
        end
      end
    end
    last_exp = e;
  endtask

  task automatic test_backpressure();
    bit fill;
    send_poly(3, 1000);
    ctl(1'b1, 1'b0);
    vert_valid_in = 1'b1;
    vert_x_in     = 32'd7;
    vert_y_in     = 32'd8;
    vert_last_in  = 1'b0;
    repeat (4) begin
      @(negedge clk_in);
      checks++; if (vert_ready_out !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b expected 0", vert_ready_out); end
    end
    swap_in = 1'b1;
    fill    = m_fill;
    @(posedge clk_in);
    if (!fill) model_clear();
    @(negedge clk_in);
    swap_in = 1'b0;
    checks++; if (vert_ready_out !== 1'b1) begin errors++; $display("FAIL bp_ready_after_swap: got %b expected 1", vert_ready_out); end
    @(posedge clk_in);
    model_beat(32'd7, 32'd8, 1'b0);
    @(negedge clk_in);
    vert_valid_in = 1'b0;
    pop_expected("bp");
    checks++; if (polygons_on_screen_out !== e.count) begin errors++; $display("FAIL bp_count: got %0d expected %0d", polygons_on_screen_out, e.count); end
    checks++; if (num_sides_out !== e.sides) begin errors++; $display("FAIL bp_sides: got %h expected %h", num_sides_out, e.sides); end
    checks++; if (xs_out[31:0] !== e.xs[31:0]) begin errors++; $display("FAIL bp_x00: got %0d expected %0d", xs_out[31:0], e.xs[31:0]); end
    // Last vertex arrives together with scene_end: polygon must be included.
    send_beat(32'd9, 32'd10, 1'b0, 1'b0);
    send_beat(32'd11, 32'd12, 1'b1, 1'b1);
    do_swap();
    pop_expected("bp2");
    checks++; if (polygons_on_screen_out !== 3'd1) begin errors++; $display("FAIL bp2_count: got %0d expected 1", polygons_on_screen_out); end
    checks++; if (polygons_on_screen_out !== e.count) begin errors++; $display("FAIL bp2_model_count: got %0d expected %0d", polygons_on_screen_out, e.count); end
    checks++; if ((xs_out[31:0] !== 32'd7) || (ys_out[31:0] !== 32'd8)) begin errors++; $display("FAIL bp2_first_vertex: got (%0d,%0d) expected (7,8)", xs_out[31:0], ys_out[31:0]); end
    checks++; if (num_sides_out !== 16'h0003) begin errors++; $display("FAIL bp2_sides: got %h expected 0003", num_sides_out); end
  endtask

  task automatic test_vertex_overflow();
    send_poly(2, 50);
    send_poly(10, -400);
    ctl(1'b1, 1'b0);
    do_swap();
    pop_expected("vo");
    checks++; if (polygons_on_screen_out !== 3'd1) begin errors++; $display("FAIL vo_count: got %0d expected 1", polygons_on_screen_out); end
    checks++; if (num_sides_out[NSW-1:0] !== 4'd8) begin errors++; $display("FAIL vo_sides0: got %0d expected 8", num_sides_out[NSW-1:0]); end
    checks++; if (overflow_out !== 1'b1) begin errors++; $display("FAIL vo_ovf: got %b expected 1", overflow_out); end
    for (int s = 0; s < TOT; s++) begin
      if (e.vmask[s]) begin
        checks++;
        if ((xs_out[s*32 +: 32] !== e.xs[s*32 +: 32]) || (ys_out[s*32 +: 32] !== e.ys[s*32 +: 32])) begin
          errors++;
          $display("FAIL vo_vertex[%0d]: got (%0d,%0d) expected (%0d,%0d)", s,
                   $signed(xs_out[s*32 +: 32]), $signed(ys_out[s*32 +: 32]),
                   $signed(e.xs[s*32 +: 32]), $signed(e.ys[s*32 +: 32]));
        end
      end
    end
  endtask

  task automatic test_polygon_overflow();
    for (int i = 0; i < 5; i++) send_poly(3, 20 + 100*i);
    ctl(1'b1, 1'b0);
    do_swap();
    pop_expected("po");
    checks++; if (polygons_on_screen_out !== 3'd4) begin errors++; $display("FAIL po_count: got %0d expected 4", polygons_on_screen_out); end
    checks++; if (overflow_out !== 1'b1) begin errors++; $display("FAIL po_ovf: got %b expected 1", overflow_out); end
    checks++; if (num_sides_out !== e.sides) begin errors++; $display("FAIL po_sides: got %h expected %h", num_sides_out, e.sides); end
    for (int s = 0; s < TOT; s++) begin
      if (e.vmask[s]) begin
        checks++;
        if ((xs_out[s*32 +: 32] !== e.xs[s*32 +: 32]) || (ys_out[s*32 +: 32] !== e.ys[s*32 +: 32])) begin
          errors++;
          $display("FAIL po_vertex[%0d]: got (%0d,%0d) expected (%0d,%0d)", s,
                   $signed(xs_out[s*32 +: 32]), $signed(ys_out[s*32 +: 32]),
                   $signed(e.xs[s*32 +: 32]), $signed(e.ys[s*32 +: 32]));
        end
      end
    end
    last_exp = e;
  endtask

  task automatic test_swap_without_commit();
    send_poly(3, 5000);
    ctl(1'b0, 1'b1);
    @(negedge clk_in);
    checks++; if (polygons_on_screen_out !== last_exp.count) begin errors++; $display("FAIL nc_count: got %0d expected %0d", polygons_on_screen_out, last_exp.count); end
    checks++; if (num_sides_out !== last_exp.sides) begin errors++; $display("FAIL nc_sides: got %h expected %h", num_sides_out, last_exp.sides); end
    checks++; if (overflow_out !== last_exp.ovf) begin errors++; $display("FAIL nc_ovf: got %b expected %b", overflow_out, last_exp.ovf); end
    checks++; if (xs_out[31:0] !== last_exp.xs[31:0]) begin errors++; $display("FAIL nc_x00: got %0d expected %0d", xs_out[31:0], last_exp.xs[31:0]); end
    // Second triangle, then an open polygon; scene_end and swap coincide while filling.
    send_poly(3, 6000);
    send_beat(32'd1, 32'd2, 1'b0, 1'b0);
    send_beat(32'd3, 32'd4, 1'b0, 1'b0);
    ctl(1'b1, 1'b1);
    @(negedge clk_in);
    checks++; if (polygons_on_screen_out !== last_exp.count) begin errors++; $display("FAIL cs_count_unchanged: got %0d expected %0d", polygons_on_screen_out, last_exp.count); end
    checks++; if (vert_ready_out !== 1'b0) begin errors++; $display("FAIL cs_committed_ready: got %b expected 0", vert_ready_out); end
    do_swap();
    pop_expected("op");
    checks++; if (polygons_on_screen_out !== 3'd2) begin errors++; $display("FAIL op_count: got %0d expected 2", polygons_on_screen_out); end
    checks++; if (num_sides_out !== 16'h0033) begin errors++; $display("FAIL op_sides: got %h expected 0033", num_sides_out); end
    checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL op_ovf: got %b expected 0", overflow_out); end
    for (int s = 0; s < TOT; s++) begin
      if (e.vmask[s]) begin
        checks++;
        if ((xs_out[s*32 +: 32] !== e.xs[s*32 +: 32]) || (ys_out[s*32 +: 32] !== e.ys[s*32 +: 32])) begin
          errors++;
          $display("FAIL op_vertex[%0d]: got (%0d,%0d) expected (%0d,%0d)", s,
                   $signed(xs_out[s*32 +: 32]), $signed(ys_out[s*32 +: 32]),
                   $signed(e.xs[s*32 +: 32]), $signed(e.ys[s*32 +: 32]));
        end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drained: got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_mid_reset();
    send_poly(3, 777);
    send_beat(32'd42, 32'd43, 1'b0, 1'b0);
    rst_in = 1'b0;
    #2;
    checks++; if (vert_ready_out !== 1'b0) begin errors++; $display("FAIL mr_ready: got %b expected 0", vert_ready_out); end
    checks++; if (polygons_on_screen_out !== '0) begin errors++; $display("FAIL mr_count: got %0d expected 0", polygons_on_screen_out); end
    checks++; if ((num_sides_out !== '0) || (overflow_out !== 1'b0)) begin errors++; $display("FAIL mr_sides_ovf: got %h/%b expected 0/0", num_sides_out, overflow_out); end
    checks++; if ((xs_out !== '0) || (ys_out !== '0)) begin errors++; $display("FAIL mr_coords: got nonzero expected 0"); end
    @(negedge clk_in);
    rst_in = 1'b1;
    model_clear();
    sb.delete();
    @(negedge clk_in);
    checks++; if (vert_ready_out !== 1'b1) begin errors++; $display("FAIL mr_release_ready: got %b expected 1", vert_ready_out); end
    checks++; if ((polygons_on_screen_out !== '0) || (xs_out !== '0)) begin errors++; $display("FAIL mr_release_front: got count %0d expected 0 and zero coords", polygons_on_screen_out); end
  endtask

  initial begin
    test_reset();
    test_scene1();
    test_backpressure();
    test_vertex_overflow();
    test_polygon_overflow();
    test_swap_without_commit();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
